ma_peak_detect: RTL and testbench

Peak/event detector that sits directly downstream of the floating-point moving-average stage and consumes its `real` output on the same `en` sample strobe. It finds excursions of the smoothed signal above a threshold and reports each excursion's peak value, the peak's sample index and the excursion width. Reports go out on a one-entry valid/ready event port toward the control/readout logic.

---
 rtl/ma_pkg.sv | 26 ++
 rtl/evt_buf1.sv | 52 +++++
 rtl/ma_peak_detect.sv | 117 +++++++++++
 tb/tb_ma_peak_detect.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
// ============================================================================
// Module   : ma_pkg
// Brief    : Shared types and constants for the moving-average and peak stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ma_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABOVE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } det_state_t;

    typedef struct {
        real                    peak;
        logic [CNT_W_DEF-1:0]   idx;
        logic [CNT_W_DEF-1:0]   width;
    } evt_rec_t;

endpackage

`default_nettype wire

// File: rtl/evt_buf1.sv
// ============================================================================
// Module   : evt_buf1
// Brief    : One-entry valid/ready event holding register with drop pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module evt_buf1 #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  real              push_peak,
    input  logic [CNT_W-1:0] push_idx,
    input  logic [CNT_W-1:0] push_width,
    output logic             evt_valid,
    input  logic             evt_ready,
    output real              evt_peak,
    output logic [CNT_W-1:0] evt_idx,
    output logic [CNT_W-1:0] evt_width,
    output logic             evt_drop
);

    logic can_load;

    // A pop in the same cycle frees the slot, so push-on-full with ready replaces.
    assign can_load = !evt_valid || evt_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_peak  <= 0.0;
            evt_idx   <= '0;
            evt_width <= '0;
            evt_drop  <= 1'b0;
        end else begin
            evt_drop <= push && !can_load;
            if (push && can_load) begin
                evt_valid <= 1'b1;
                evt_peak  <= push_peak;
                evt_idx   <= push_idx;
                evt_width <= push_width;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ma_peak_detect.sv
// ============================================================================
// Module   : ma_peak_detect
// Brief    : Threshold excursion detector reporting peak, index and width.
//            Define MA_PEAK_HYST_EN to add thr_lo release hysteresis.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ma_peak_detect
    import ma_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MIN_WIDTH = 2,
    parameter int HOLDOFF   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  real              ma_in,
    input  real              thr_hi,
`ifdef MA_PEAK_HYST_EN
    input  real              thr_lo,
`endif
    output logic             evt_valid,
    input  logic             evt_ready,
    output real              evt_peak,
    output logic [CNT_W-1:0] evt_idx,
    output logic [CNT_W-1:0] evt_width,
    output logic             evt_drop
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    det_state_t         state;
    logic [CNT_W-1:0]   sample_idx;
    real                peak;
    logic [CNT_W-1:0]   pidx;
    logic [CNT_W-1:0]   width;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               rel;
    logic               push;

`ifdef MA_PEAK_HYST_EN
    assign rel = ma_in < thr_lo;
`else
    assign rel = ma_in <= thr_hi;
`endif

    assign push = en && (state == ST_ABOVE) && rel && (width >= CNT_W'(MIN_WIDTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sample_idx <= '0;
            peak       <= 0.0;
            pidx       <= '0;
            width      <= '0;
            hold_cnt   <= '0;
        end else if (en) begin
            sample_idx <= sample_idx + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ma_in > thr_hi) begin
                        peak  <= ma_in;
                        pidx  <= sample_idx;
                        width <= CNT_W'(1);
                        state <= ST_ABOVE;
                    end
                end
                ST_ABOVE: begin
                    if (rel) begin
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            hold_cnt <= HOLD_W'(HOLDOFF);
                            state    <= ST_HOLDOFF;
                        end
                    end else begin
                        if (width != '1)
                            width <= width + 1'b1;
                        // Strict compare keeps the first index on ties.
                        if (ma_in > peak) begin
                            peak <= ma_in;
                            pidx <= sample_idx;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt <= HOLD_W'(1))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    evt_buf1 #(
        .CNT_W (CNT_W)
    ) u_evt_buf1 (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_peak  (peak),
        .push_idx   (pidx),
        .push_width (width),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_peak   (evt_peak),
        .evt_idx    (evt_idx),
        .evt_width  (evt_width),
        .evt_drop   (evt_drop)
    );

endmodule

`default_nettype wire

// File: tb/tb_ma_peak_detect.sv
// ============================================================================
// Module   : tb_ma_peak_detect
// Brief    : Directed self-checking bench for ma_peak_detect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ma_peak_detect;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             en;
    real              ma_in;
    real              thr_hi;
    real              thr_lo;
    logic             evt_valid;
    logic             evt_ready;
    real              evt_peak;
    logic [CNT_W-1:0] evt_idx;
    logic [CNT_W-1:0] evt_width;
    logic             evt_drop;

    int checks = 0;
    int errors = 0;

    ma_peak_detect #(
        .CNT_W     (CNT_W),
        .MIN_WIDTH (2),
        .HOLDOFF   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ma_in     (ma_in),
        .thr_hi    (thr_hi),
`ifdef MA_PEAK_HYST_EN
        .thr_lo    (thr_lo),
`endif
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_peak  (evt_peak),
        .evt_idx   (evt_idx),
        .evt_width (evt_width),
        .evt_drop  (evt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic smp(input real v);
        ma_in = v;
        en    = 1'b1;
        @(posedge clk);
        #1;
        en    = 1'b0;
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) smp(0.0);
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic chk_evt(input string tag, input real pk, input int idx, input int w);
        check({tag, ".valid"}, 64'(evt_valid), 64'd1);
        check({tag, ".peak"},  $realtobits(evt_peak), $realtobits(pk));
        check({tag, ".idx"},   64'(evt_idx), 64'(idx));
        check({tag, ".width"}, 64'(evt_width), 64'(w));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".valid"}, 64'(evt_valid), 64'd0);
        check({tag, ".drop"},  64'(evt_drop), 64'd0);
        check({tag, ".peak"},  $realtobits(evt_peak), $realtobits(0.0));
        check({tag, ".idx"},   64'(evt_idx), 64'd0);
        check({tag, ".width"}, 64'(evt_width), 64'd0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ma_in = 0.0; evt_ready = 1'b0;
        thr_hi = 1.0; thr_lo = 0.5;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic excursion, indices 0..4
        smp(0.5); smp(1.5); smp(3.0); smp(2.0);
        check("basic.early", 64'(evt_valid), 64'd0);
        smp(0.2);
        chk_evt("basic", 3.0, 2, 3);
        pop();
        check("basic.pop", 64'(evt_valid), 64'd0);
        pad(8);                                       // holdoff 5..12

        // One-sample spike, indices 13..15
        smp(0.0); smp(5.0); smp(0.0);
        check("spike.valid", 64'(evt_valid), 64'd0);
        pad(8);                                       // 16..23

        // Equal peaks, indices 24..27
        smp(0.0); smp(2.0); smp(2.0); smp(0.0);
        chk_evt("tie", 2.0, 25, 2);
        pop();
        pad(8);                                       // 28..35

        // Buffer full: first event 36..38, second 47..49 dropped
        smp(2.0); smp(3.0); smp(0.0);
        chk_evt("full1", 3.0, 37, 2);
        pad(8);                                       // 39..46
        smp(4.0); smp(4.0);
        check("full.nodrop", 64'(evt_drop), 64'd0);
        smp(0.0);
        check("full.drop", 64'(evt_drop), 64'd1);
        chk_evt("full.keep", 3.0, 37, 2);
        @(posedge clk);
        #1;
        check("full.droppulse", 64'(evt_drop), 64'd0);
        check("full.stillvalid", 64'(evt_valid), 64'd1);
        pop();
        check("full.pop", 64'(evt_valid), 64'd0);
        pad(8);                                       // 50..57

        // Holdoff: release at 60, ignored 62..64, reported from 69
        smp(2.0); smp(2.5); smp(0.0);
        chk_evt("hold1", 2.5, 59, 2);
        pop();
        smp(0.0); smp(3.0); smp(3.0); smp(3.0);
        smp(0.0); smp(0.0); smp(0.0); smp(0.0);       // 61..68
        check("hold.ignored", 64'(evt_valid), 64'd0);
        smp(3.0); smp(3.5); smp(3.0); smp(0.0);       // 69..72
        chk_evt("hold2", 3.5, 70, 3);
        pop();
        pad(8);                                       // 73..80

        // Hysteresis samples, indices 81..84
        smp(1.5); smp(0.8); smp(0.8); smp(0.4);
`ifdef MA_PEAK_HYST_EN
        chk_evt("hyst", 1.5, 81, 3);
        pop();
`else
        check("nohyst.valid", 64'(evt_valid), 64'd0);
`endif
        pad(8);                                       // 85..92

        // Pending event plus excursion in progress, then reset
        smp(2.0); smp(3.0); smp(0.0);                 // 93..95
        chk_evt("pend", 3.0, 94, 2);
        pad(8);                                       // 96..103
        smp(5.0); smp(5.0);                           // ABOVE
        rst = 1'b0;
        #2;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        smp(0.0);                                     // idx 0, stays idle
        check("postrst.noevt", 64'(evt_valid), 64'd0);
        smp(2.0); smp(3.0); smp(0.0);                 // 1..3
        chk_evt("postrst", 3.0, 2, 2);
        pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
